chroma_upsample_ctrl: RTL and testbench



---
 rtl/chroma_upsample_ctrl_pkg.sv | 30 +++
 rtl/chroma_upsample_ctrl_supersample.sv | 31 +++
 rtl/chroma_upsample_ctrl.sv | 132 +++++++++++++
 tb/tb_chroma_upsample_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_upsample_ctrl_pkg.sv
// chroma_upsample_ctrl_pkg
// Shared types and constants for the 4:2:0 chroma upsampling controller:
// the 8x8 block of 9-bit signed samples, the channel tags, the controller
// FSM states and the number of luma blocks per MCU.
package chroma_upsample_ctrl_pkg;

  localparam int PIX_W     = 9;
  localparam int BLK_DIM   = 8;
  localparam int Y_PER_MCU = 4;
  localparam int CH_W      = 2;

  localparam logic [CH_W-1:0] CH_Y  = 2'd0;
  localparam logic [CH_W-1:0] CH_CB = 2'd1;
  localparam logic [CH_W-1:0] CH_CR = 2'd2;

  typedef logic signed [PIX_W-1:0] pix_t;
  typedef pix_t [BLK_DIM-1:0][BLK_DIM-1:0] block_t;

  typedef enum logic [1:0] {S_Y, S_CB, S_CR, S_EMIT} state_t;

  // Channel tag the controller is waiting for in a given state.
  function automatic logic [CH_W-1:0] expected_ch(input state_t s);
    case (s)
      S_CB:    return CH_CB;
      S_CR:    return CH_CR;
      default: return CH_Y;
    endcase
  endfunction

endpackage

// File: rtl/chroma_upsample_ctrl_supersample.sv
// supersample_8x8
// Zero-latency 2x nearest-neighbour chroma upsampler. One 8x8 chroma block
// becomes four 8x8 quadrants; quadrant q covers source rows (q>>1)*4..+3 and
// source columns (q&1)*4..+3, each source sample replicated into a 2x2 patch.
// Ports:
//   valid_in   block_in is presented this cycle
//   ch         channel tag (only Cb or Cr produce valid output)
//   block_in   source chroma block
//   valid_out  one valid bit per quadrant
//   quad       the four upsampled quadrants, index = quadrant
module supersample_8x8
  import chroma_upsample_ctrl_pkg::*;
(
  input  logic            valid_in,
  input  logic [CH_W-1:0] ch,
  input  block_t          block_in,
  output logic [3:0]      valid_out,
  output block_t [3:0]    quad
);

  for (genvar q = 0; q < 4; q++) begin : g_quad
    for (genvar r = 0; r < BLK_DIM; r++) begin : g_row
      for (genvar c = 0; c < BLK_DIM; c++) begin : g_col
        assign quad[q][r][c] = block_in[(q / 2) * 4 + r / 2][(q % 2) * 4 + c / 2];
      end
    end
  end

  assign valid_out = (valid_in && (ch == CH_CB || ch == CH_CR)) ? 4'hF : 4'h0;

endmodule

// File: rtl/chroma_upsample_ctrl.sv
// chroma_upsample_ctrl
// Collects one 4:2:0 MCU (four Y blocks, then Cb, then Cr), upsamples Cb and
// Cr through one shared supersample_8x8 and emits four aligned (Y, Cb, Cr)
// triples, quadrant q pairing with the q-th Y block received.
// Optional feature macro: CHROMA_CTRL_CHK_EN -- when defined, a block whose
// channel tag does not match the expected channel is consumed but dropped and
// err_out becomes sticky; when undefined, blocks are assigned by position.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   valid_in, ch, block_in, ready_out   input block handshake
//   valid_out, ready_in, quad_out, y_out, cb_out, cr_out  output triple
//   err_out               sticky channel-tag error
//   state_dbg             current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready_out and valid_out depend only on registered state, and a
// presented triple stays unchanged until it is taken.
module chroma_upsample_ctrl
  import chroma_upsample_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [CH_W-1:0] ch,
  input  block_t          block_in,
  output logic            ready_out,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [1:0]      quad_out,
  output block_t          y_out,
  output block_t          cb_out,
  output block_t          cr_out,
  output logic            err_out,
  output state_t          state_dbg
);

  localparam logic [1:0] Y_LAST = 2'(Y_PER_MCU - 1);

  state_t          state, state_nx;
  logic [1:0]      ycnt, qcnt;
  block_t [3:0]    ybuf, cbbuf, crbuf;
  logic [CH_W-1:0] exp_ch;
  logic            in_fire, out_fire, ch_ok;
  logic            y_store, cb_latch, cr_latch;
  logic            dp_valid_in;
  logic [3:0]      dp_valid;
  block_t [3:0]    dp_quad;

  supersample_8x8 u_ss (
    .valid_in  (dp_valid_in),
    .ch        (exp_ch),
    .block_in  (block_in),
    .valid_out (dp_valid),
    .quad      (dp_quad)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_Y;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_Y:     if (y_store && ycnt == Y_LAST) state_nx = S_CB;
      S_CB:    if (cb_latch) state_nx = S_CR;
      S_CR:    if (cr_latch) state_nx = S_EMIT;
      S_EMIT:  if (out_fire && qcnt == 2'd3) state_nx = S_Y;
      default: state_nx = S_Y;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    ready_out = (state != S_EMIT);
    valid_out = (state == S_EMIT);
    exp_ch    = expected_ch(state);
  end

  assign in_fire     = valid_in && ready_out;
  assign out_fire    = valid_out && ready_in;
  assign dp_valid_in = in_fire && (state == S_CB || state == S_CR);

`ifdef CHROMA_CTRL_CHK_EN
  assign ch_ok = (ch == exp_ch);

  always_ff @(posedge clock) begin
    if (reset)                 err_out <= 1'b0;
    else if (in_fire && !ch_ok) err_out <= 1'b1;
  end
`else
  // Sequencing is positional; the tag is deliberately ignored.
  logic unused_ch;
  assign unused_ch = ^ch;
  assign ch_ok     = 1'b1;
  assign err_out   = 1'b0;
`endif

  assign y_store  = in_fire && ch_ok && (state == S_Y);
  assign cb_latch = in_fire && ch_ok && (state == S_CB) && (dp_valid == 4'hF);
  assign cr_latch = in_fire && ch_ok && (state == S_CR) && (dp_valid == 4'hF);

  // Block buffers and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      ycnt  <= '0;
      qcnt  <= '0;
      ybuf  <= '0;
      cbbuf <= '0;
      crbuf <= '0;
    end else begin
      if (y_store) begin
        ybuf[ycnt] <= block_in;
        ycnt       <= ycnt + 2'd1;
      end
      if (cb_latch) cbbuf <= dp_quad;
      if (cr_latch) begin
        crbuf <= dp_quad;
        qcnt  <= '0;
      end
      if (out_fire) qcnt <= qcnt + 2'd1;
    end
  end

  assign quad_out  = qcnt;
  assign y_out     = ybuf[qcnt];
  assign cb_out    = cbbuf[qcnt];
  assign cr_out    = crbuf[qcnt];
  assign state_dbg = state;

endmodule

// File: tb/tb_chroma_upsample_ctrl.sv
// tb_chroma_upsample_ctrl
// Self-checking bench for chroma_upsample_ctrl. Inputs change and outputs are
// sampled on the falling clock edge; expected triples are queued when an MCU
// is driven and compared as the controller emits them.
module tb_chroma_upsample_ctrl;
  import chroma_upsample_ctrl_pkg::*;

  localparam int BW = $bits(block_t);
  localparam int TW = 2 + 3 * BW;

  logic            clock;
  logic            reset;
  logic            valid_in;
  logic [CH_W-1:0] ch;
  block_t          block_in;
  logic            ready_out;
  logic            valid_out;
  logic            ready_in;
  logic [1:0]      quad_out;
  block_t          y_out, cb_out, cr_out;
  logic            err_out;
  state_t          state_dbg;

  logic [TW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  chroma_upsample_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (valid_in),
    .ch        (ch),
    .block_in  (block_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .quad_out  (quad_out),
    .y_out     (y_out),
    .cb_out    (cb_out),
    .cr_out    (cr_out),
    .err_out   (err_out),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  function automatic block_t fill(input int v);
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = 9'(v);
    return b;
  endfunction

  function automatic block_t rand_block();
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = 9'($urandom_range(511));
    return b;
  endfunction

  // Nearest-neighbour 2x upsample of one chroma quadrant, built source-first.
  function automatic block_t ref_quad(input block_t b, input int q);
    block_t o;
    int r0 = (q / 2) * 4;
    int c0 = (q % 2) * 4;
    for (int sr = 0; sr < 4; sr++)
      for (int sc = 0; sc < 4; sc++) begin
        o[2*sr][2*sc]     = b[r0+sr][c0+sc];
        o[2*sr][2*sc+1]   = b[r0+sr][c0+sc];
        o[2*sr+1][2*sc]   = b[r0+sr][c0+sc];
        o[2*sr+1][2*sc+1] = b[r0+sr][c0+sc];
      end
    return o;
  endfunction

  function automatic logic [1:0] e_q(input logic [TW-1:0] e);  return e[TW-1 -: 2];    endfunction
  function automatic block_t     e_y(input logic [TW-1:0] e);  return e[3*BW-1 -: BW]; endfunction
  function automatic block_t     e_cb(input logic [TW-1:0] e); return e[2*BW-1 -: BW]; endfunction
  function automatic block_t     e_cr(input logic [TW-1:0] e); return e[BW-1:0];       endfunction

  // ---------------- driver tasks ----------------
  // Starts and ends on a falling edge; holds the block until one transfer.
  task automatic send_block(input logic [CH_W-1:0] c, input block_t b, output bit ok);
    int n = 0;
    valid_in = 1'b1;
    ch       = c;
    block_in = b;
    while (ready_out !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    ok = (ready_out === 1'b1);
    @(posedge clock);
    @(negedge clock);
    valid_in = 1'b0;
  endtask

  task automatic send_mcu(input block_t ys[4], input block_t cb, input block_t cr, output bit ok);
    bit k;
    ok = 1'b1;
    for (int q = 0; q < 4; q++)
      exp_q.push_back({2'(q), ys[q], ref_quad(cb, q), ref_quad(cr, q)});
    for (int i = 0; i < 4; i++) begin
      send_block(CH_Y, ys[i], k);
      ok &= k;
    end
    send_block(CH_CB, cb, k);
    ok &= k;
    send_block(CH_CR, cr, k);
    ok &= k;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (valid_out !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    ok = (valid_out === 1'b1);
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (state_dbg !== S_Y) begin n_err++; $display("FAIL reset_state: got %0d exp %0d", state_dbg, S_Y); end
    n_cmp++;
    if (ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready_out: got %b exp 1", ready_out); end
    n_cmp++;
    if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b exp 0", valid_out); end
    n_cmp++;
    if (quad_out !== 2'd0) begin n_err++; $display("FAIL reset_quad_out: got %0d exp 0", quad_out); end
    n_cmp++;
    if (err_out !== 1'b0) begin n_err++; $display("FAIL reset_err_out: got %b exp 0", err_out); end
    n_cmp++;
    if ({y_out, cb_out, cr_out} !== '0) begin n_err++; $display("FAIL reset_buffers: y=%h exp 0", y_out); end
  endtask

  task automatic test_basic();
    block_t ys[4];
    bit ok;
    logic [TW-1:0] e;
    int c0;
    ys[0] = fill(10); ys[1] = fill(20); ys[2] = fill(30); ys[3] = fill(40);
    ready_in = 1'b1;
    c0 = cyc;
    send_mcu(ys, fill(5), fill(-7), ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL basic_send: input handshake timed out, got ok=%b exp 1", ok); end
    n_cmp++;
    if (valid_out !== 1'b1) begin n_err++; $display("FAIL basic_valid_rise: got %b exp 1 one cycle after Cr", valid_out); end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (valid_out !== 1'b1) begin n_err++; $display("FAIL basic_valid%0d: got %b exp 1", k, valid_out); end
      n_cmp++;
      if (quad_out !== e_q(e)) begin n_err++; $display("FAIL basic_quad%0d: got %0d exp %0d", k, quad_out, e_q(e)); end
      n_cmp++;
      if (y_out !== e_y(e)) begin n_err++; $display("FAIL basic_y%0d: got %h exp %h", k, y_out, e_y(e)); end
      n_cmp++;
      if (cb_out !== fill(5)) begin n_err++; $display("FAIL basic_cb%0d: got %h exp %h", k, cb_out, fill(5)); end
      n_cmp++;
      if (cr_out !== fill(-7)) begin n_err++; $display("FAIL basic_cr%0d: got %h exp %h", k, cr_out, fill(-7)); end
      @(posedge clock);
      @(negedge clock);
    end
    n_cmp++;
    if (ready_out !== 1'b1 || valid_out !== 1'b0 || (cyc - c0) !== 10)
      begin n_err++; $display("FAIL basic_cycle11: got ready=%b valid=%b cycles=%0d exp 1 0 10", ready_out, valid_out, cyc - c0); end
  endtask

  task automatic test_quadrant();
    block_t ys[4];
    block_t cb;
    bit ok;
    logic [TW-1:0] e;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) cb[r][c] = 9'(r * 8 + c);
    for (int i = 0; i < 4; i++) ys[i] = rand_block();
    ready_in = 1'b1;
    send_mcu(ys, cb, rand_block(), ok);
    for (int k = 0; k < 4; k++) begin
      wait_out(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL quad_timeout%0d: got no valid_out exp valid", k); end
      n_cmp++;
      if (quad_out !== e_q(e)) begin n_err++; $display("FAIL quad_idx%0d: got %0d exp %0d", k, quad_out, e_q(e)); end
      n_cmp++;
      if (y_out !== e_y(e)) begin n_err++; $display("FAIL quad_y%0d: got %h exp %h", k, y_out, e_y(e)); end
      n_cmp++;
      if (cb_out !== e_cb(e)) begin n_err++; $display("FAIL quad_cb%0d: got %h exp %h", k, cb_out, e_cb(e)); end
      n_cmp++;
      if (cr_out !== e_cr(e)) begin n_err++; $display("FAIL quad_cr%0d: got %h exp %h", k, cr_out, e_cr(e)); end
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    block_t ys[4];
    bit ok;
    logic [TW-1:0] e;
    for (int i = 0; i < 4; i++) ys[i] = rand_block();
    ready_in = 1'b1;
    send_mcu(ys, rand_block(), rand_block(), ok);
    for (int k = 0; k < 4; k++) begin
      wait_out(ok);
      e = exp_q.pop_front();
      if (k == 2) begin
        // Stall quadrant 2 while offering a block upstream.
        ready_in = 1'b0;
        valid_in = 1'b1;
        ch       = CH_Y;
        block_in = fill(99);
        for (int s = 0; s < 5; s++) begin
          n_cmp++;
          if (quad_out !== 2'd2 || valid_out !== 1'b1 || ready_out !== 1'b0 || state_dbg !== S_EMIT)
            begin n_err++; $display("FAIL bp_ctrl%0d: got q=%0d v=%b r=%b st=%0d exp 2 1 0 3", s, quad_out, valid_out, ready_out, state_dbg); end
          n_cmp++;
          if (y_out !== e_y(e) || cb_out !== e_cb(e) || cr_out !== e_cr(e))
            begin n_err++; $display("FAIL bp_data%0d: got y=%h exp %h", s, y_out, e_y(e)); end
          @(posedge clock);
          @(negedge clock);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
      end
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL bp_timeout%0d: got no valid_out exp valid", k); end
      n_cmp++;
      if (quad_out !== e_q(e)) begin n_err++; $display("FAIL bp_quad%0d: got %0d exp %0d", k, quad_out, e_q(e)); end
      n_cmp++;
      if (y_out !== e_y(e)) begin n_err++; $display("FAIL bp_y%0d: got %h exp %h", k, y_out, e_y(e)); end
      n_cmp++;
      if (cb_out !== e_cb(e)) begin n_err++; $display("FAIL bp_cb%0d: got %h exp %h", k, cb_out, e_cb(e)); end
      n_cmp++;
      if (cr_out !== e_cr(e)) begin n_err++; $display("FAIL bp_cr%0d: got %h exp %h", k, cr_out, e_cr(e)); end
      @(posedge clock);
      @(negedge clock);
    end
    n_cmp++;
    if (state_dbg !== S_Y || ready_out !== 1'b1) begin n_err++; $display("FAIL bp_after: got st=%0d r=%b exp 0 1", state_dbg, ready_out); end
  endtask

  task automatic test_channel();
    block_t y[4];
    block_t junk, cb, cr;
    block_t ys[4];
    bit ok, k;
    logic [TW-1:0] e;
    for (int i = 0; i < 4; i++) y[i] = rand_block();
    junk = rand_block();
    cb   = rand_block();
    cr   = rand_block();
    ready_in = 1'b1;
    ok = 1'b1;
    send_block(CH_Y, y[0], k); ok &= k;
    send_block(CH_Y, y[1], k); ok &= k;
    send_block(CH_CB, junk, k); ok &= k;
`ifdef CHROMA_CTRL_CHK_EN
    n_cmp++;
    if (err_out !== 1'b1 || state_dbg !== S_Y) begin n_err++; $display("FAIL chk_err: got err=%b st=%0d exp 1 0", err_out, state_dbg); end
    ys[0] = y[0]; ys[1] = y[1]; ys[2] = y[2]; ys[3] = y[3];
    for (int q = 0; q < 4; q++) exp_q.push_back({2'(q), ys[q], ref_quad(cb, q), ref_quad(cr, q)});
    send_block(CH_Y, y[2], k); ok &= k;
    send_block(CH_Y, y[3], k); ok &= k;
`else
    n_cmp++;
    if (err_out !== 1'b0 || state_dbg !== S_Y) begin n_err++; $display("FAIL pos_err: got err=%b st=%0d exp 0 0", err_out, state_dbg); end
    ys[0] = y[0]; ys[1] = y[1]; ys[2] = junk; ys[3] = y[2];
    for (int q = 0; q < 4; q++) exp_q.push_back({2'(q), ys[q], ref_quad(cb, q), ref_quad(cr, q)});
    send_block(CH_Y, y[2], k); ok &= k;
`endif
    send_block(CH_CB, cb, k); ok &= k;
    send_block(CH_CR, cr, k); ok &= k;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL chan_send: input handshake timed out, got ok=%b exp 1", ok); end
    for (int j = 0; j < 4; j++) begin
      wait_out(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL chan_timeout%0d: got no valid_out exp valid", j); end
      n_cmp++;
      if (quad_out !== e_q(e)) begin n_err++; $display("FAIL chan_quad%0d: got %0d exp %0d", j, quad_out, e_q(e)); end
      n_cmp++;
      if (y_out !== e_y(e)) begin n_err++; $display("FAIL chan_y%0d: got %h exp %h", j, y_out, e_y(e)); end
      n_cmp++;
      if (cb_out !== e_cb(e)) begin n_err++; $display("FAIL chan_cb%0d: got %h exp %h", j, cb_out, e_cb(e)); end
      n_cmp++;
      if (cr_out !== e_cr(e)) begin n_err++; $display("FAIL chan_cr%0d: got %h exp %h", j, cr_out, e_cr(e)); end
      @(posedge clock);
      @(negedge clock);
    end
`ifdef CHROMA_CTRL_CHK_EN
    n_cmp++;
    if (err_out !== 1'b1) begin n_err++; $display("FAIL chk_sticky: got %b exp 1", err_out); end
`endif
  endtask

  task automatic test_reset_mid();
    block_t ys[4];
    bit ok, k;
    logic [TW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      send_block(CH_Y, fill(100 + i), k);
    end
    send_block(CH_CB, fill(77), k);
    apply_reset();
    n_cmp++;
    if (state_dbg !== S_Y || valid_out !== 1'b0 || ready_out !== 1'b1 || err_out !== 1'b0)
      begin n_err++; $display("FAIL rst_mid_ctrl: got st=%0d v=%b r=%b err=%b exp 0 0 1 0", state_dbg, valid_out, ready_out, err_out); end
    n_cmp++;
    if ({y_out, cb_out, cr_out} !== '0) begin n_err++; $display("FAIL rst_mid_clear: got y=%h exp 0", y_out); end
    for (int i = 0; i < 4; i++) ys[i] = rand_block();
    ready_in = 1'b1;
    send_mcu(ys, rand_block(), rand_block(), ok);
    for (int j = 0; j < 4; j++) begin
      wait_out(ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rst_mid_timeout%0d: got no valid_out exp valid", j); end
      n_cmp++;
      if (quad_out !== e_q(e)) begin n_err++; $display("FAIL rst_mid_quad%0d: got %0d exp %0d", j, quad_out, e_q(e)); end
      n_cmp++;
      if (y_out !== e_y(e)) begin n_err++; $display("FAIL rst_mid_y%0d: got %h exp %h", j, y_out, e_y(e)); end
      n_cmp++;
      if (cb_out !== e_cb(e)) begin n_err++; $display("FAIL rst_mid_cb%0d: got %h exp %h", j, cb_out, e_cb(e)); end
      n_cmp++;
      if (cr_out !== e_cr(e)) begin n_err++; $display("FAIL rst_mid_cr%0d: got %h exp %h", j, cr_out, e_cr(e)); end
      n_cmp++;
      if (err_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_err%0d: got %b exp 0", j, err_out); end
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    block_t ya[4], yb[4];
    block_t cba, cra, cbb, crb;
    bit oka, okb;
    int t_start[2];
    for (int i = 0; i < 4; i++) begin
      ya[i] = rand_block();
      yb[i] = rand_block();
    end
    cba = rand_block(); cra = rand_block();
    cbb = rand_block(); crb = rand_block();
    ready_in = 1'b1;
    oka = 1'b0;
    okb = 1'b0;
    t_start[0] = 0;
    t_start[1] = 0;
    fork
      begin
        send_mcu(ya, cba, cra, oka);
        send_mcu(yb, cbb, crb, okb);
      end
      begin
        bit ok;
        logic [TW-1:0] e;
        for (int j = 0; j < 8; j++) begin
          wait_out(ok);
          e = exp_q.pop_front();
          if (j == 0 || j == 4) t_start[j / 4] = cyc;
          n_cmp++;
          if (!ok) begin n_err++; $display("FAIL b2b_timeout%0d: got no valid_out exp valid", j); end
          n_cmp++;
          if (quad_out !== e_q(e)) begin n_err++; $display("FAIL b2b_quad%0d: got %0d exp %0d", j, quad_out, e_q(e)); end
          n_cmp++;
          if (y_out !== e_y(e)) begin n_err++; $display("FAIL b2b_y%0d: got %h exp %h", j, y_out, e_y(e)); end
          n_cmp++;
          if (cb_out !== e_cb(e)) begin n_err++; $display("FAIL b2b_cb%0d: got %h exp %h", j, cb_out, e_cb(e)); end
          n_cmp++;
          if (cr_out !== e_cr(e)) begin n_err++; $display("FAIL b2b_cr%0d: got %h exp %h", j, cr_out, e_cr(e)); end
          @(posedge clock);
          @(negedge clock);
        end
      end
    join
    n_cmp++;
    if (!(oka && okb)) begin n_err++; $display("FAIL b2b_send: input handshake timed out, got %b%b exp 11", oka, okb); end
    n_cmp++;
    if (t_start[1] - t_start[0] !== 10) begin n_err++; $display("FAIL b2b_period: got %0d cycles exp 10", t_start[1] - t_start[0]); end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL b2b_leftover: got %0d queued exp 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    ch       = '0;
    block_in = '0;
    ready_in = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_quadrant();
    test_backpressure();
    test_channel();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
